// File: rtl/sd_cmd_response_rx.sv
// -----------------------------------------------------------------------------
// sd_cmd_response_rx
//   Receives the SD card response frame on the CMD line once the command block
//   has finished sending a command. Deserialises 48-bit (R1/R3/R6/R7) or
//   136-bit (R2) frames, checks CRC7, command index, transmission bit and end
//   bit, then offers the payload to the response register.
//
// Ports
//   clock            in   system clock, all logic on the rising edge
//   reset            in   synchronous, active-high reset
//   sd_clk_en        in   1-cycle strobe at each SD-clock CMD sampling point
//   cmd_pin_in       in   CMD line from the card
//   start            in   1-cycle pulse: command end bit has been transmitted
//   resp_type        in   00 none, 01 136-bit, 10 48-bit, 11 48-bit with busy
//   crc_check_en     in   enable CRC7 check
//   index_check_en   in   enable index check (48-bit frames only)
//   expected_index   in   index of the command just sent
//   ack_response     in   response register has captured the payload
//   response         out  128-bit payload
//   enable_response  out  payload valid, held until ack_response
//   busy             out  high whenever the FSM is not IDLE
//   done             out  1-cycle pulse when a transaction finishes
//   timeout_err      out  no start bit within TIMEOUT_CYCLES strobes
//   crc_err          out  CRC7 mismatch
//   index_err        out  index mismatch
//   frame_err        out  end bit 0 or transmission bit 1
//   dbg_state        out  current FSM state (IDLE=0 WAIT_START=1 RECEIVE=2
//                         CHECK=3 HANDOFF=4)
//
// Handshake: enable_response acts as "valid" and ack_response as "ready". The
// payload is transferred on the rising edge where both are high; response
// stays stable while enable_response is high and ack_response is ignored at
// any other time.
// -----------------------------------------------------------------------------
module sd_cmd_response_rx #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         sd_clk_en,
   input  logic         cmd_pin_in,
   input  logic         start,
   input  logic [1:0]   resp_type,
   input  logic         crc_check_en,
   input  logic         index_check_en,
   input  logic [5:0]   expected_index,
   input  logic         ack_response,
   output logic [127:0] response,
   output logic         enable_response,
   output logic         busy,
   output logic         done,
   output logic         timeout_err,
   output logic         crc_err,
   output logic         index_err,
   output logic         frame_err,
   output logic [2:0]   dbg_state
);

   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_WAIT_START = 3'd1,
      S_RECEIVE    = 3'd2,
      S_CHECK      = 3'd3,
      S_HANDOFF    = 3'd4
   } state_e;

   state_e             state_q, state_d;
   logic [1:0]         type_q, type_d;
   logic               crc_en_q, crc_en_d;
   logic               idx_en_q, idx_en_d;
   logic [5:0]         exp_idx_q, exp_idx_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic [7:0]         bit_cnt_q, bit_cnt_d;
   // 135 bits are enough: the start bit of a 136-bit frame is always 0 and
   // falls off the top without loss.
   logic [134:0]       shift_q, shift_d;
   logic [6:0]         crc_q, crc_d;
   logic [127:0]       response_q, response_d;
   logic               done_q, done_d;
   logic               timeout_err_q, timeout_err_d;
   logic               crc_err_q, crc_err_d;
   logic               index_err_q, index_err_d;
   logic               frame_err_q, frame_err_d;

   logic               long_frame;
   logic [7:0]         bit_k;
   logic [7:0]         frame_len;
   logic [TMO_W-1:0]   tmo_inc;
   logic               tmo_hit;
   logic               crc_covered;

   // Serial CRC7, generator x^7 + x^3 + 1
   function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
      logic fb;
      fb = c[6] ^ b;
      return {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
   endfunction

   assign long_frame = (type_q == 2'b01);
   assign frame_len  = long_frame ? 8'd136 : 8'd48;
   // bit_k is the 1-based number of the frame bit being sampled now
   assign bit_k      = bit_cnt_q + 8'd1;
   assign tmo_inc    = tmo_q + 1'b1;
   assign tmo_hit    = (tmo_inc == TMO_W'(TIMEOUT_CYCLES));
   // CRC covers frame bits 47..8 (short) or 127..8 (long); for the long frame
   // the start, transmission and six reserved bits are skipped.
   assign crc_covered = long_frame ? ((bit_k >= 8'd9) && (bit_k <= 8'd128))
                                   : (bit_k <= 8'd40);

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start && (resp_type != 2'b00)) state_d = S_WAIT_START;
         end
         S_WAIT_START: begin
            if (sd_clk_en) begin
               if (!cmd_pin_in)  state_d = S_RECEIVE;
               else if (tmo_hit) state_d = S_IDLE;
            end
         end
         S_RECEIVE: begin
            if (sd_clk_en && (bit_k == frame_len)) state_d = S_CHECK;
         end
         S_CHECK: begin
            state_d = S_HANDOFF;
         end
         S_HANDOFF: begin
            if (ack_response) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------ datapath next
   always_comb begin
      type_d        = type_q;
      crc_en_d      = crc_en_q;
      idx_en_d      = idx_en_q;
      exp_idx_d     = exp_idx_q;
      tmo_d         = tmo_q;
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      crc_d         = crc_q;
      response_d    = response_q;
      done_d        = 1'b0;
      timeout_err_d = timeout_err_q;
      crc_err_d     = crc_err_q;
      index_err_d   = index_err_q;
      frame_err_d   = frame_err_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               type_d        = resp_type;
               crc_en_d      = crc_check_en;
               idx_en_d      = index_check_en;
               exp_idx_d     = expected_index;
               tmo_d         = '0;
               bit_cnt_d     = '0;
               shift_d       = '0;
               crc_d         = '0;
               timeout_err_d = 1'b0;
               crc_err_d     = 1'b0;
               index_err_d   = 1'b0;
               frame_err_d   = 1'b0;
               done_d        = (resp_type == 2'b00);
            end
         end
         S_WAIT_START, S_RECEIVE: begin
            if (sd_clk_en) begin
               if ((state_q == S_RECEIVE) || !cmd_pin_in) begin
                  shift_d   = {shift_q[133:0], cmd_pin_in};
                  bit_cnt_d = bit_k;
                  if (crc_covered) crc_d = crc7_step(crc_q, cmd_pin_in);
               end else begin
                  tmo_d = tmo_inc;
                  if (tmo_hit) begin
                     timeout_err_d = 1'b1;
                     done_d        = 1'b1;
                  end
               end
            end
         end
         S_CHECK: begin
            crc_err_d   = crc_en_q && (crc_q != shift_q[7:1]);
            index_err_d = idx_en_q && !long_frame && (shift_q[45:40] != exp_idx_q);
            frame_err_d = !shift_q[0] || (long_frame ? shift_q[134] : shift_q[46]);
            response_d  = long_frame ? {8'h00, shift_q[127:8]}
                                     : {96'h0, shift_q[39:8]};
         end
         S_HANDOFF: begin
            if (ack_response) done_d = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // ---------------------------------------------------------- datapath regs
   always_ff @(posedge clock) begin
      if (reset) begin
         type_q        <= '0;
         crc_en_q      <= 1'b0;
         idx_en_q      <= 1'b0;
         exp_idx_q     <= '0;
         tmo_q         <= '0;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         crc_q         <= '0;
         response_q    <= '0;
         done_q        <= 1'b0;
         timeout_err_q <= 1'b0;
         crc_err_q     <= 1'b0;
         index_err_q   <= 1'b0;
         frame_err_q   <= 1'b0;
      end else begin
         type_q        <= type_d;
         crc_en_q      <= crc_en_d;
         idx_en_q      <= idx_en_d;
         exp_idx_q     <= exp_idx_d;
         tmo_q         <= tmo_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         crc_q         <= crc_d;
         response_q    <= response_d;
         done_q        <= done_d;
         timeout_err_q <= timeout_err_d;
         crc_err_q     <= crc_err_d;
         index_err_q   <= index_err_d;
         frame_err_q   <= frame_err_d;
      end
   end

   // ----------------------------------------------------------------- outputs
   always_comb begin
      busy            = (state_q != S_IDLE);
      enable_response = (state_q == S_HANDOFF);
      dbg_state       = state_q;
   end

   assign response    = response_q;
   assign done        = done_q;
   assign timeout_err = timeout_err_q;
   assign crc_err     = crc_err_q;
   assign index_err   = index_err_q;
   assign frame_err   = frame_err_q;

endmodule
